// File: rtl/gate_vector_checker.sv
// gate_vector_checker: drives a 2-input gate through all four input
// vectors, samples its output after a hold time and counts mismatches.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request a full 4-vector run (ignored while busy)
//   y                  output of the gate under test
//   a, b               stimulus to the gate under test
//   busy, done, pass   run status; pass = done and zero mismatches
//   err_count          mismatch count of the last or current run (0..4)
//   vec_idx            index of the vector currently driven ({a,b})
//   first_fail_valid,  only with GVC_FIRST_FAIL_CAPTURE_EN defined:
//   first_fail_vec     index of the first mismatching vector of a run
//
// Parameters:
//   HOLD_CYCLES        cycles each vector is held before y is sampled (2..255)
//   TRUTH_TABLE        bit v is the expected y for {a,b} = v
module gate_vector_checker #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [3:0]  TRUTH_TABLE = 4'b1110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] vec_idx
`ifdef GVC_FIRST_FAIL_CAPTURE_EN
    ,
    output logic       first_fail_valid,
    output logic [1:0] first_fail_vec
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [1:0] vec_q;
    logic [2:0] err_q;

    logic sample;
    logic mismatch;
    logic start_run;

    // Sampling happens on the last cycle of each vector's hold window.
    assign sample    = (state_q == DRIVE) && (cnt_q == LAST_CNT);
    assign mismatch  = sample && (y != TRUTH_TABLE[vec_q]);
    assign start_run = start && (state_q != DRIVE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = DRIVE;
            end
            DRIVE: begin
                if (sample && (vec_q == 2'd3)) state_d = DONE;
            end
            DONE: begin
                if (start) state_d = DRIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: a/b follow vec_idx only while driving, so they drop
    // back to 0 on the same edge that enters DONE.
    always_comb begin
        a         = 1'b0;
        b         = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        err_count = err_q;
        vec_idx   = vec_q;
        unique case (state_q)
            DRIVE: begin
                a    = vec_q[1];
                b    = vec_q[0];
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                pass = (err_q == 3'd0);
            end
            default: begin
                a = 1'b0;
            end
        endcase
    end

    // Hold counter, vector index and mismatch counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            vec_q <= 2'd0;
            err_q <= 3'd0;
        end else if (start_run) begin
            cnt_q <= 8'd0;
            vec_q <= 2'd0;
            err_q <= 3'd0;
        end else if (state_q == DRIVE) begin
            if (sample) begin
                cnt_q <= 8'd0;
                // vec_idx stays at 3 so DONE reports the final vector.
                if (vec_q != 2'd3) vec_q <= vec_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (mismatch && (err_q != 3'd4)) err_q <= err_q + 3'd1;
        end
    end

`ifdef GVC_FIRST_FAIL_CAPTURE_EN
    logic       ff_valid_q;
    logic [1:0] ff_vec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_valid_q <= 1'b0;
            ff_vec_q   <= 2'd0;
        end else if (start_run) begin
            ff_valid_q <= 1'b0;
            ff_vec_q   <= 2'd0;
        end else if (mismatch && !ff_valid_q) begin
            ff_valid_q <= 1'b1;
            ff_vec_q   <= vec_q;
        end
    end

    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// Testbench for gate_vector_checker: table-driven, random and
// hand-written multi-cycle sequences against a simple gate model.
module tb_gate_vector_checker;

    localparam int H = 20;
    localparam int H2 = 2;
    localparam logic [3:0] TT = 4'b1110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [3:0] gate = 4'b1110;
    logic [3:0] gate2 = 4'b1000;

    logic       y, a, b, busy, done, pass;
    logic [2:0] err_count;
    logic [1:0] vec_idx;
    logic       y2, a2, b2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [1:0] vec2;
`ifdef GVC_FIRST_FAIL_CAPTURE_EN
    logic       ffv, ffv2;
    logic [1:0] ffi, ffi2;
`endif

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Gate under test: y is the gate's truth table indexed by {a,b}.
    assign y  = gate[{a, b}];
    assign y2 = gate2[{a2, b2}];

    gate_vector_checker #(.HOLD_CYCLES(H), .TRUTH_TABLE(TT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y(y),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_idx(vec_idx)
`ifdef GVC_FIRST_FAIL_CAPTURE_EN
        , .first_fail_valid(ffv), .first_fail_vec(ffi)
`endif
    );

    gate_vector_checker #(.HOLD_CYCLES(H2), .TRUTH_TABLE(TT)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .y(y2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .vec_idx(vec2)
`ifdef GVC_FIRST_FAIL_CAPTURE_EN
        , .first_fail_valid(ffv2), .first_fail_vec(ffi2)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: mismatches are the differing truth-table bits.
    function automatic int ref_err(input logic [3:0] g);
        return $countones(g ^ TT);
    endfunction

    function automatic int ref_first(input logic [3:0] g);
        for (int v = 0; v < 4; v++)
            if (g[v] != TT[v]) return v;
        return 0;
    endfunction

    // One full run on dut; optional extra start pulse at cycle pulse_at.
    task automatic run(input string name, input logic [3:0] g,
                       input int pulse_at);
        int edges;
        int bad_ab;
        int exp_v;
        gate = g;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({name, " busy@start"}, int'(busy), 1);
        edges = 0;
        bad_ab = 0;
        while (!done && edges < 400) begin
            @(negedge clk);
            exp_v = edges / H;
            if ({a, b} != 2'(exp_v)) bad_ab++;
            start = (pulse_at > 0) && (edges == pulse_at);
            @(posedge clk);
            #1 edges++;
            start = 1'b0;
        end
        chk({name, " latency"}, edges, 4 * H);
        chk({name, " ab_seq_errs"}, bad_ab, 0);
        chk({name, " err_count"}, int'(err_count), ref_err(g));
        chk({name, " pass"}, int'(pass), int'(ref_err(g) == 0));
        chk({name, " done_ab_vec"}, int'({busy, a, b, vec_idx}), 3);
`ifdef GVC_FIRST_FAIL_CAPTURE_EN
        chk({name, " ff_valid"}, int'(ffv), int'(ref_err(g) != 0));
        if (ref_err(g) != 0)
            chk({name, " ff_vec"}, int'(ffi), ref_first(g));
`endif
    endtask

    typedef struct {
        string      name;
        logic [3:0] g;
        int         exp_err;
        logic       exp_pass;
    } vec_t;

    vec_t tbl[4];
    int   wait_cnt;

    initial begin
        tbl[0] = '{"or",  4'b1110, 0, 1'b1};
        tbl[1] = '{"and", 4'b1000, 2, 1'b0};
        tbl[2] = '{"one", 4'b1111, 1, 1'b0};
        tbl[3] = '{"zero", 4'b0000, 3, 1'b0};

        // Reset state and no auto-start
        #23;
        chk("reset_outs", int'({a, b, busy, done, pass, err_count, vec_idx}), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("no_autostart", int'({busy, done}), 0);

        // Table-driven runs
        for (int i = 0; i < 4; i++) begin
            run(tbl[i].name, tbl[i].g, 0);
            chk({tbl[i].name, " tbl_err"}, int'(err_count), tbl[i].exp_err);
            chk({tbl[i].name, " tbl_pass"}, int'(pass), int'(tbl[i].exp_pass));
        end

        // DONE holds its results
        repeat (3) @(posedge clk);
        #1 chk("done_hold", int'({done, pass, err_count}), {1'b1, 1'b0, 3'd3});

        // Re-pulse start at cycle 30: ignored
        run("repulse", 4'b1000, 30);

        // Random gates
        for (int i = 0; i < 6; i++)
            run("rand", 4'($urandom_range(0, 15)), 0);

        // Reset while vec_idx=2
        gate = 4'b1110;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_cnt = 0;
        while (vec_idx != 2'd2 && wait_cnt < 200) begin
            @(posedge clk);
            #1 wait_cnt++;
        end
        chk("reach_vec2", int'(vec_idx), 2);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", int'({a, b, busy, done, pass, err_count, vec_idx}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("idle_after_rst", int'(busy), 0);
        run("post_rst", 4'b1110, 0);

        // HOLD_CYCLES=2: failing run, then restart from DONE
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("h2_done", int'(done2), 1);
        chk("h2_err", int'(err2), 2);
        @(negedge clk);
        gate2 = 4'b1110;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        chk("h2_restart", int'({done2, busy2, err2}), {1'b0, 1'b1, 3'd0});
`ifdef GVC_FIRST_FAIL_CAPTURE_EN
        chk("h2_ff_clr", int'(ffv2), 0);
`endif
        repeat (7) @(posedge clk);
        #1 chk("h2_not_yet", int'(done2), 0);
        @(posedge clk);
        #1 chk("h2_done2", int'({done2, pass2, err2}), {1'b1, 1'b1, 3'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
